// File: rtl/iru_tile_pingpong_buffer.sv
// Double-buffered DIM x DIM tile store: CH write channels fill one bank while
// the other bank streams whole rows out over valid/ready.
module iru_tile_pingpong_buffer #(
  parameter  int DIM = 20,
  parameter  int CH  = 5,
  parameter  int DW  = 8,
  localparam int IW  = $clog2(DIM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              z,
  input  logic [CH-1:0]     wr,
  input  logic [CH*DW-1:0]  d,
  input  logic [CH*IW-1:0]  row,
  input  logic [CH*IW-1:0]  col,
  input  logic              done,
  output logic              fill_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IW-1:0]     out_row,
  output logic              out_last,
  output logic [DIM*DW-1:0] out_data,
  output logic              collision,
  output logic              drop
);

  localparam logic [IW-1:0] LAST_ROW = IW'(DIM - 1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t         state, state_nxt;
  logic           fill_sel, drain_sel;
  logic           pending, pending_nxt;
  logic [IW-1:0]  out_row_nxt;
  logic           hs, last_hs, done_ok, swap;
  logic [CH-1:0]  acc;
  logic           coll_c, drop_c;
  logic [DW-1:0]  mem [2][DIM][DIM];

  function automatic logic in_range(input logic [IW-1:0] idx);
    return 32'(idx) < DIM;
  endfunction

  assign drain_sel  = ~fill_sel;
  assign fill_ready = ~pending;
  assign out_valid  = (state == DRAIN);
  assign out_last   = out_valid & (out_row == LAST_ROW);

  // Accepted writes, drop and same-address collision detection
  always_comb begin
    acc    = '0;
    drop_c = 1'b0;
    coll_c = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (wr[i]) begin
        if (fill_ready && in_range(row[i*IW +: IW]) && in_range(col[i*IW +: IW]))
          acc[i] = ~z;
        else
          drop_c = 1'b1;
      end
    end
    for (int i = 0; i < CH; i++) begin
      for (int j = i + 1; j < CH; j++) begin
        if (acc[i] && acc[j] && row[i*IW +: IW] == row[j*IW +: IW] &&
            col[i*IW +: IW] == col[j*IW +: IW])
          coll_c = 1'b1;
      end
    end
  end

  // A swap happens either straight from idle, or on the final row handshake
  // when a finished fill tile is waiting.
  always_comb begin
    hs          = out_valid & out_ready;
    last_hs     = hs & (out_row == LAST_ROW);
    done_ok     = done & fill_ready & ~z;
    swap        = ~z & ((done_ok & ((state == IDLE) | last_hs)) | (pending & last_hs));
    state_nxt   = state;
    out_row_nxt = out_row;
    pending_nxt = pending;
    if (hs) out_row_nxt = last_hs ? '0 : out_row + 1'b1;
    if (last_hs) state_nxt = IDLE;
    if (swap) begin
      state_nxt   = DRAIN;
      out_row_nxt = '0;
    end
    if (z || swap) pending_nxt = 1'b0;
    else if (done_ok && state == DRAIN) pending_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_row   <= '0;
      pending   <= 1'b0;
      fill_sel  <= 1'b0;
      collision <= 1'b0;
      drop      <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_row   <= out_row_nxt;
      pending   <= pending_nxt;
      fill_sel  <= fill_sel ^ swap;
      collision <= coll_c;
      drop      <= drop_c;
    end
  end

  // Drain bank is cleared as its last row leaves, so it returns as a clean fill bank.
  // Channels are applied high-to-low so the lowest index wins a shared address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < DIM; r++)
          for (int c = 0; c < DIM; c++)
            mem[b][r][c] <= '0;
    end else begin
      if (last_hs)
        for (int r = 0; r < DIM; r++)
          for (int c = 0; c < DIM; c++)
            mem[drain_sel][r][c] <= '0;
      if (z) begin
        for (int r = 0; r < DIM; r++)
          for (int c = 0; c < DIM; c++)
            mem[fill_sel][r][c] <= '0;
      end else begin
        for (int i = CH - 1; i >= 0; i--)
          if (acc[i])
            mem[fill_sel][row[i*IW +: IW]][col[i*IW +: IW]] <= d[i*DW +: DW];
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int c = 0; c < DIM; c++)
      out_data[c*DW +: DW] = mem[drain_sel][out_row][c];
  end

endmodule

// File: doc/iru_tile_pingpong_buffer.md
Name: iru_tile_pingpong_buffer

Overview:
Parametrised, double-buffered successor to the IRU output tile buffer. Holds two DIM x DIM tiles of DW-bit pixels. CH write channels fill one bank at random row/col addresses while the other bank streams out whole rows over a valid/ready interface. It resolves same-address write contention deterministically and flags dropped or colliding writes. It sits between the IRU rotation datapath (writer) and the downstream tile consumer (reader).

Parameters:
DIM, 20, tile edge length in pixels (rows = cols = DIM), >= 2
CH, 5, number of independent write channels, >= 1
DW, 8, pixel width in bits
IW, $clog2(DIM), row/col index width (derived, not overridden)

Ports:
clk  input  1  clock
rst_n  input  1  async active-low reset
z  input  1  sync clear of the fill bank and any pending handoff
wr  input  CH  per-channel write strobe
d  input  CH*DW  per-channel pixel; channel i at [i*DW +: DW]
row  input  CH*IW  per-channel row index; channel i at [i*IW +: IW]
col  input  CH*IW  per-channel column index; channel i at [i*IW +: IW]
done  input  1  pulse: current fill tile complete, hand off to drain
fill_ready  output  1  fill bank accepts writes/done
out_valid  output  1  out_data holds a valid row
out_ready  input  1  consumer accepts row
out_row  output  IW  row index of out_data
out_last  output  1  out_row == DIM-1 while out_valid
out_data  output  DIM*DW  row pixels; column c at [c*DW +: DW]
collision  output  1  registered pulse: >=2 channels wrote the same address
drop  output  1  registered pulse: write lost (fill_ready=0 or index >= DIM)

Behaviour:
- Reset (rst_n=0, async): both banks zeroed. fill bank = 0. Drain idle. fill_ready=1, out_valid=0, out_row=0, collision=0, drop=0, pending=0.
- Writes: on a posedge with fill_ready=1, each wr[i] with row,col < DIM writes d[i] to fill_bank[row][col].
- Contention: the lowest-index channel wins. collision=1 on the next cycle; other writes that cycle still land.
- Out-of-range index, or any wr while fill_ready=0: write ignored, drop=1 on the next cycle.
- Handoff: done with fill_ready=1 while drain is idle -> next cycle the banks swap. Writes in the done cycle are included in the outgoing tile. New fill bank is all-zero (guaranteed by release clear). out_valid=1 with out_row=0.
- done while drain is busy -> pending=1, fill_ready=0 from the next cycle. The swap happens on the edge where the last row is accepted (out_valid & out_ready & out_last). In the following cycle out_valid stays 1, out_row=0, fill_ready=1.
- done while fill_ready=0: ignored.
- Drain FSM, two states:
  - IDLE: out_valid=0.
  - DRAIN: out_data = drain_bank[out_row], combinational from storage.
  - On out_valid & out_ready: out_row increments.
  - On the last row: drain bank zeroed on that edge, then -> IDLE, or -> DRAIN with swapped banks if pending.
  - out_data/out_row held stable while out_valid & !out_ready.
- Throughput: one row per cycle with out_ready held high. Tile drain takes DIM cycles.
- z: the fill bank is zeroed and pending cleared next edge, and fill_ready=1. z has priority over same-cycle wr and done. The drain bank and drain FSM are unaffected.
- Reset mid-drain or mid-fill: immediate return to reset state; no partial output.

Test Plan:
- Fill/drain: write pixel (r*DIM+c)&0xFF to every address via channels round-robin, pulse done, out_ready=1 -> out_valid next cycle, 20 consecutive rows, row 5 col 3 = 0x67, out_last on row 19, then out_valid=0.
- Contention: channels 0,2,4 write (7,7) with 0x11,0x22,0x33 in one cycle -> collision=1 next cycle, drained (7,7)=0x11.
- Backpressure/pending: second tile done while the first is draining with out_ready toggling 1/0 -> fill_ready=0, writes during the stall raise drop and are not stored. The second tile starts the cycle after the first out_last handshake with no gap and correct data.
- Release clear: fill tile A and drain it; then fill tile B writing only (0,0)=0xAA and drain -> every other pixel reads 0x00.
- z vs done: z and done in the same cycle after partial writes -> no swap, out_valid stays 0, a later done drains an all-zero tile. Index row=20 -> drop=1, no storage change.
- Async reset asserted mid-drain at row 9 -> out_valid=0 immediately, fill_ready=1, subsequent drained tile is all-zero except new writes.
